// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the round-robin UART arbiter and the UART.
// master = arbiter side, slave = requester/UART side.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 7
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_psel;
  logic [NREQ-1:0]    gnt;
  logic               uart_start;
  logic [DW-1:0]      uart_data;
  logic               uart_psel;
  logic               uart_done;
  logic               busy;
  logic               timeout;

  modport master (
    input  req, req_data, req_psel, uart_done,
    output gnt, uart_start, uart_data, uart_psel, busy, timeout
  );

  modport slave (
    output req, req_data, req_psel, uart_done,
    input  gnt, uart_start, uart_data, uart_psel, busy, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// Optional WAIT_DONE watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int DW             = 7,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.master  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  if (NREQ < 2 || NREQ > 8 || DW < 1 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_tx_arbiter: parameter out of range");
  end

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            start_q, start_d;
  logic [DW-1:0]   data_q, data_d;
  logic            psel_q, psel_d;
  logic            busy_q, busy_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            timeout_q, timeout_d;
  logic            wd_expire;

  logic [DW-1:0]   req_word [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_word
    assign req_word[gi] = bus.req_data[gi*DW +: DW];
  end

  // Scan offsets from high to low so the lowest offset from rr_ptr wins.
  logic          req_any;
  logic [PW-1:0] pick;

  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    req_any = 1'b0;
    pick    = '0;
    sum     = '0;
    idx     = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(o);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (bus.req[idx]) begin
        req_any = 1'b1;
        pick    = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = '0;
    start_d   = 1'b0;
    data_d    = data_q;
    psel_d    = psel_q;
    busy_d    = busy_q;
    gap_cnt_d = gap_cnt_q;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          data_d   = req_word[pick];
          psel_d   = bus.req_psel[pick];
          rr_ptr_d = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
          gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          start_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.uart_done || wd_expire) begin
          timeout_d = ~bus.uart_done;
          gap_cnt_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      default: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
          busy_d    = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
      psel_q    <= 1'b0;
      busy_q    <= 1'b0;
      gap_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      start_q   <= start_d;
      data_q    <= data_d;
      psel_q    <= psel_d;
      busy_q    <= busy_d;
      gap_cnt_q <= gap_cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt_q;

  // Counter is zero on entry to WAIT_DONE; expiry after TIMEOUT_CYCLES waiting cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else if (state_q != S_WAIT) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  assign wd_expire = (state_q == S_WAIT) && (wd_cnt_q == WW'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expire = 1'b0;
`endif

  assign bus.gnt        = gnt_q;
  assign bus.uart_start = start_q;
  assign bus.uart_data  = data_q;
  assign bus.uart_psel  = psel_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single request, reset, round-robin, wrap, withdrawn request, watchdog.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 7;
  localparam int GAP  = 16;
  localparam int TMO  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  logic [DW-1:0]   dval [NREQ] = '{7'h11, 7'h22, 7'h55, 7'h7E};
  logic [NREQ-1:0] psel_v = 4'b0110;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  uart_tx_arbiter #(
    .NREQ(NREQ), .DW(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.uart_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("start_seen", 32'(ok), 32'd1);
  endtask

  // One arbitrated frame: expect grant k, then model uart_done ~50 cycles after start.
  task automatic run_frame(input int k, input logic [NREQ-1:0] next_req);
    bit ok;
    wait_start(ok);
    check_val($sformatf("gnt_k%0d", k), 32'(bus.gnt), 32'(4'b0001 << k));
    check_val($sformatf("data_k%0d", k), 32'(bus.uart_data), 32'(dval[k]));
    check_val($sformatf("psel_k%0d", k), 32'(bus.uart_psel), 32'(psel_v[k]));
    bus.req = next_req;
    step();
    check_val("start_width", 32'(bus.uart_start), 32'd0);
    repeat (48) step();
    check_val($sformatf("data_hold_k%0d", k), 32'(bus.uart_data), 32'(dval[k]));
    bus.uart_done = 1'b1;
    step();
    bus.uart_done = 1'b0;
    $display("frame: gnt=%b data=%h psel=%b busy=%b", 4'b0001 << k, dval[k], psel_v[k], bus.busy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "global timeout");
  end

  initial begin
    bit ok;
    bit seen;
    int n;
    bus.req       = '0;
    bus.req_data  = {dval[3], dval[2], dval[1], dval[0]};
    bus.req_psel  = psel_v;
    bus.uart_done = 1'b0;

    // Reset state
    #100;
    check_val("rst_busy",  32'(bus.busy), 32'd0);
    check_val("rst_gnt",   32'(bus.gnt), 32'd0);
    check_val("rst_start", 32'(bus.uart_start), 32'd0);
    check_val("rst_data",  32'(bus.uart_data), 32'd0);
    check_val("rst_tmo",   32'(bus.timeout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Single request from requester 2
    bus.req = 4'b0100;
    step();
    check_val("single_gnt",   32'(bus.gnt), 32'h4);
    check_val("single_start", 32'(bus.uart_start), 32'd1);
    check_val("single_data",  32'(bus.uart_data), 32'h55);
    check_val("single_psel",  32'(bus.uart_psel), 32'd1);
    bus.req = '0;
    step();
    check_val("single_gnt_w",   32'(bus.gnt), 32'd0);
    check_val("single_start_w", 32'(bus.uart_start), 32'd0);
    check_val("single_busy",    32'(bus.busy), 32'd1);
    repeat (10) step();
    check_val("single_data_hold", 32'(bus.uart_data), 32'h55);
    bus.uart_done = 1'b1;
    step();
    bus.uart_done = 1'b0;
    repeat (GAP - 1) step();
    check_val("gap_busy_hi", 32'(bus.busy), 32'd1);
    step();
    check_val("gap_busy_lo", 32'(bus.busy), 32'd0);
    $display("frame: single request gnt=0100 data=55");

    // Reset mid-frame: rr_ptr is 3, so requester 1 is granted first
    bus.req = 4'b0010;
    wait_start(ok);
    check_val("pre_rst_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    step();
    step();
    rst = 1'b1;
    #1;
    check_val("arst_busy",  32'(bus.busy), 32'd0);
    check_val("arst_data",  32'(bus.uart_data), 32'd0);
    check_val("arst_psel",  32'(bus.uart_psel), 32'd0);
    check_val("arst_start", 32'(bus.uart_start), 32'd0);
    $display("reset: asserted during WAIT_DONE");
    bus.req = 4'b1111;
    step();
    rst = 1'b0;

    // Round-robin with all requesting, then wrap from 3 to 0
    run_frame(0, 4'b1111);
    run_frame(1, 4'b1111);
    run_frame(2, 4'b1111);
    run_frame(3, 4'b1111);
    run_frame(0, 4'b1111);
    run_frame(1, 4'b1000);
    run_frame(3, 4'b1001);
    run_frame(0, 4'b1000);
    run_frame(3, 4'b0000);

    // Request raised and withdrawn inside the gap
    seen = 1'b0;
    bus.req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step();
      seen |= bus.uart_start | bus.gnt[1];
    end
    bus.req = '0;
    for (int i = 0; i < 30; i++) begin
      step();
      seen |= bus.uart_start | bus.gnt[1];
    end
    check_val("withdrawn_gnt", 32'(seen), 32'd0);
    check_val("withdrawn_idle", 32'(bus.busy), 32'd0);
    $display("withdrawn: req[1] pulsed in gap, granted=%b", seen);

    // UART never answers
    bus.req = 4'b0001;
    wait_start(ok);
    check_val("tmo_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
`ifdef UART_ARB_TIMEOUT_EN
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (bus.timeout === 1'b1) begin
        n = i;
        break;
      end
    end
    // START cycle, then TMO waiting cycles, pulse on the following cycle
    check_val("tmo_latency", 32'(n), 32'(TMO + 1));
    step();
    check_val("tmo_width", 32'(bus.timeout), 32'd0);
    repeat (GAP - 2) step();
    check_val("tmo_gap_busy", 32'(bus.busy), 32'd1);
    step();
    check_val("tmo_idle", 32'(bus.busy), 32'd0);
    $display("timeout: pulse after %0d cycles", n);
`else
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.timeout === 1'b1) n++;
    end
    check_val("hang_busy", 32'(bus.busy), 32'd1);
    check_val("hang_tmo_pulses", 32'(n), 32'd0);
    $display("timeout: disabled, busy=%b after 200 cycles", bus.busy);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (7-bit data, parity select, `start` strobe) among NREQ requesters using round-robin arbitration.
- Sequences each frame: grant, start pulse, wait for the UART's done pulse, then an inter-frame gap.
- Sits between the requesting blocks and the UART top; drives its `start`, `data_in` and `p_sel` inputs.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 7, data width per frame; matches the UART data_in width
- GAP_CYCLES, 16, idle clock cycles enforced after each frame; 0 means no gap
- TIMEOUT_CYCLES, 1_000_000, watchdog limit in WAIT_DONE (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester frame request, level; held until the matching gnt bit is seen
- req_data  in  NREQ*DW  packed data; requester i uses bits [i*DW +: DW]
- req_psel  in  NREQ  per-requester parity select
- gnt  out  NREQ  one-hot, single-cycle pulse; marks the frame as accepted
- uart_start  out  1  single-cycle start strobe to the UART
- uart_data  out  DW  frame data to the UART; stable from START through WAIT_DONE
- uart_psel  out  1  parity select to the UART; stable with uart_data
- uart_done  in  1  single-cycle pulse from the UART at end of the stop bit
- busy  out  1  high whenever state != IDLE
- timeout  out  1  single-cycle pulse when the watchdog fires

Behaviour:
- Reset, asynchronous on rst high:
  - state = IDLE, rr_ptr = 0.
  - gnt, uart_start, uart_data, uart_psel, busy, timeout, gap_cnt, wd_cnt all 0.
  - Reset mid-frame aborts immediately; uart_start is never left asserted.
- IDLE:
  - If any req is high, select the first set bit searching upward from rr_ptr, wrapping modulo NREQ. Call it index k.
  - On that same edge: latch req_data[k] into uart_data and req_psel[k] into uart_psel, set rr_ptr = (k+1) mod NREQ, go to START.
  - If no req is high, stay in IDLE.
- START, one cycle:
  - uart_start = 1 and gnt[k] = 1 in this cycle only.
  - Next state is WAIT_DONE.
  - Latency: req sampled high at edge n gives gnt and uart_start high during cycle n+1.
- WAIT_DONE:
  - Hold uart_data and uart_psel.
  - On uart_done = 1, go to GAP, or to IDLE if GAP_CYCLES = 0.
  - uart_done is ignored in every other state.
- GAP:
  - gap_cnt counts 0..GAP_CYCLES-1; then go to IDLE with gap_cnt cleared.
  - req is not sampled during GAP.
- Request rules:
  - A req dropped before the IDLE sampling edge is not granted.
  - Once latched, the frame is committed; later changes to req, req_data or req_psel do not affect it.
  - A requester that keeps req high after gnt is treated as a new request and rejoins arbitration.
- Fairness: with all req high, grants go 0,1,2,3,0,... No requester waits more than NREQ-1 frames.
- Frame period: back-to-back frame spacing is the UART frame time + 2 + GAP_CYCLES clocks.
- busy is registered and tracks the state: 0 in IDLE only.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - wd_cnt increments each cycle in WAIT_DONE and clears on entry.
  - On reaching TIMEOUT_CYCLES without uart_done: pulse timeout for one cycle and go to GAP, or to IDLE if GAP_CYCLES = 0.
  - uart_done arriving in the same cycle as expiry takes priority, and no timeout pulse is issued.
- Not defined: WAIT_DONE waits indefinitely, timeout is tied to 0, and no wd_cnt logic exists.

Test Plan:
- Single request:
  - Stimulus: rst 100 ns, then req=4'b0100 with data[2]=7'b1010101, psel[2]=1.
  - Response: next cycle gnt=4'b0100 and uart_start=1, each one cycle wide; uart_data=7'h55 and uart_psel=1 held until uart_done.
  - busy returns to 0 exactly GAP_CYCLES+1 cycles after uart_done.
- Round-robin:
  - Stimulus: req=4'b1111 held, uart_done modelled 50 cycles after each start.
  - Response: grant order 0,1,2,3,0,1; each uart_data equals the granted requester's data.
- Wrap priority:
  - Stimulus: after a grant to index 3, req=4'b1001.
  - Response: next grant goes to 0, then 3.
- Withdrawn request:
  - Stimulus: req[1] pulsed high only during GAP.
  - Response: no gnt[1] and no uart_start.
- Reset mid-frame:
  - Stimulus: rst asserted in WAIT_DONE.
  - Response: all outputs 0 asynchronously; after release, the first grant goes to requester 0.
- Timeout (macro defined, TIMEOUT_CYCLES=100):
  - Stimulus: uart_done never arrives.
  - Response: timeout pulses 100 cycles after START and the arbiter returns to IDLE after the gap.
  - With the macro undefined, busy stays 1.
